// File: rtl/digit_serial_alu.sv
// digit_serial_alu: WIDTH-bit ALU that works LSB-first, DIGIT bits per clock, with a registered carry chain and start/done handshake
module digit_serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       F,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             carry_flag
);
  localparam int N = WIDTH / DIGIT;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, res_n;
  logic [3:0] f_r;
  logic [KW-1:0] k;
  logic c, arith, ovf, accept;
  logic [DIGIT-1:0] as, br, bs, slice;
  logic [DIGIT:0] sum;
  always_comb begin
    accept = start && state != RUN;
    arith = f_r inside {4'b0010, 4'b0110, 4'b0011, 4'b0111};
    as = a_r[k*DIGIT +: DIGIT];
    br = b_r[k*DIGIT +: DIGIT];
    bs = br ^ {DIGIT{f_r[2]}};
    sum = {1'b0, as} + {1'b0, bs} + {{DIGIT{1'b0}}, c};
    ovf = as[DIGIT-1] ^ bs[DIGIT-1] ^ sum[DIGIT-1] ^ sum[DIGIT];
    slice = f_r == 4'b0000 ? as & br :
            f_r == 4'b0001 ? as | br :
            f_r == 4'b0100 ? as ^ br :
            f_r == 4'b1100 ? ~(as | br) :
            arith ? sum[DIGIT-1:0] : '0;
    res_n = result;
    res_n[k*DIGIT +: DIGIT] = slice;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      f_r <= '0;
      k <= '0;
      c <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      carry_flag <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      a_r <= a;
      b_r <= b;
      f_r <= F;
      k <= '0;
      c <= F[0] ? carry_flag : F[2];
      busy <= 1'b1;
      done <= 1'b0;
      result <= '0;
    end else if (state == RUN) begin
      result <= res_n;
      c <= sum[DIGIT];
      k <= k + 1'b1;
      if (k == KLAST) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        cout <= arith && sum[DIGIT];
        overflow <= arith && ovf;
        zero <= res_n == '0;
        carry_flag <= arith ? sum[DIGIT] : carry_flag;
      end
    end else if (state == DONE) begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: doc/digit_serial_alu.md
Name: digit_serial_alu

Overview:
- Multi-cycle, parametrised ALU that processes WIDTH-bit operands LSB-first in DIGIT-bit slices, one slice per clock, with a registered carry chain between slices.
- Generalises our 4-bit function-code carry-in decode: subtract still forces carry-in = 1, and new add/subtract-with-carry modes take carry-in from a stored carry flag.
- Sits in the execute stage of the multi-cycle CPU.
- The control FSM drives a start/done handshake and holds off while busy is high.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; N = WIDTH/DIGIT cycles per operation, N >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when accepting (see Behaviour).
- F  input  4  function code, latched with the operands.
- a  input  WIDTH  operand A, latched on accept.
- b  input  WIDTH  operand B, latched on accept.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  result; held until the next accept.
- cout  output  1  final carry-out (arithmetic ops), else 0.
- overflow  output  1  signed overflow (arithmetic ops), else 0.
- zero  output  1  result == 0.
- carry_flag  output  1  stored carry, used by ADC/SBC.

Behaviour:
- Reset: rst_n low at a clock edge clears everything to 0: result, cout, overflow, zero, carry_flag, busy, done. FSM goes to IDLE. An in-flight operation is aborted with no done pulse.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, digit counter k = 0..N-1.
  - DONE: busy=0, done=1, lasts one cycle.
- Accept: start=1 in IDLE or DONE latches a, b and F, clears the result register, and sets k=0. The FSM then moves to RUN. start is ignored in RUN, and latched operands are unaffected by input changes.
- Back-to-back: start in DONE is accepted, so done=1 and busy=1 are never high in the same cycle.
- RUN cycle k: compute slice k (bits k*DIGIT .. k*DIGIT+DIGIT-1) and write it to result. For arithmetic, register the slice carry-out as the next slice carry-in.
- After slice N-1 is written, the FSM moves to DONE.
- Latency: with the accepting edge as edge 0, result and flags are final and done=1 exactly N edges later. busy is high for exactly N cycles.
- Function codes:
  - 0000 AND, 0001 OR, 0100 XOR, 1100 NOR.
  - 0010 ADD: inverted-B = 0, cin = 0.
  - 0110 SUB: inverted-B = 1, cin = 1.
  - 0011 ADC: inverted-B = 0, cin = carry_flag.
  - 0111 SBC: inverted-B = 1, cin = carry_flag.
  - Any other code: result = 0, cout = 0, overflow = 0, zero = 1, carry_flag unchanged. done still pulses after N cycles.
- carry_flag for ADC/SBC is the value at the accepting edge.
- Flags (written on the final slice edge):
  - cout = carry out of bit WIDTH-1. For SUB/SBC, cout = 1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = full WIDTH result == 0.
  - carry_flag <= cout for arithmetic codes only; logic and illegal codes leave it unchanged.
- Intermediate visibility: during RUN, result shows completed slices, with unfinished slices still 0. cout, overflow and zero keep their previous values until the final edge.
- N=1: single RUN cycle; done one edge after accept.

Test Plan:
- WIDTH=32, DIGIT=8. ADD a=0xFFFFFFFF, b=0x00000001 -> done exactly 4 edges after accept, with:
  - result=0x00000000
  - cout=1, zero=1, overflow=0, carry_flag=1
  - busy high for 4 cycles
- SUB a=5, b=7 -> result=0xFFFFFFFE, cout=0, overflow=0, zero=0.
- Carry chain, run immediately after the ADD test:
  - ADC a=0, b=0 -> result=0x00000001, carry_flag=0.
  - Then SUB 0x80000000 - 1 -> result=0x7FFFFFFF, overflow=1, cout=1.
- Handshake:
  - Pulse start with new operands during RUN -> ignored; the original result completes.
  - start asserted while done=1 -> accepted; the next done arrives 4 edges later.
- Reset and illegal code:
  - rst_n=0 at k=2 of an ADD -> the next cycle shows all outputs 0, IDLE, and no done pulse.
  - F=1111 -> result=0, zero=1, carry_flag unchanged.
- Parameter sweep: WIDTH=8, DIGIT=8 (N=1) and WIDTH=16, DIGIT=4 (N=4), random ops -> match a reference model, with latency = N.
